// File: rtl/product_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : product_accumulator_pkg                                        |
// | Purpose : Shared types and default widths for the product accumulator.   |
// |           state_e  - ACCUM (taking products) / HOLD (result presented)   |
// |           DEF_*    - default product, accumulator and counter widths     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package product_accumulator_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_CNT_W  = 8;

endpackage : product_accumulator_pkg
`default_nettype wire

// File: rtl/product_accumulator_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : product_accumulator_sat_add                                    |
// | Purpose : Combinational unsigned saturating adder.                       |
// |           a   [W-1:0]    accumulator operand                             |
// |           b   [OP_W-1:0] addend, zero-extended to W bits                 |
// |           sum [W-1:0]    a+b, clamped to all ones on carry-out           |
// |           ovf            carry-out of the unclamped sum                  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module product_accumulator_sat_add #(
  parameter int W    = 16,
  parameter int OP_W = 8
) (
  input  logic [W-1:0]    a,
  input  logic [OP_W-1:0] b,
  output logic [W-1:0]    sum,
  output logic            ovf
);

  // One extra bit captures the carry; OP_W <= W so the extension is non-empty.
  logic [W:0] b_ext;
  logic [W:0] full;

  assign b_ext = {{(W + 1 - OP_W){1'b0}}, b};
  assign full  = {1'b0, a} + b_ext;
  assign ovf   = full[W];
  assign sum   = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule : product_accumulator_sat_add
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : product_accumulator                                            |
// | Purpose : Sums a stream of multiplier products into a saturating         |
// |           accumulator; a group closed by prod_last is presented as a     |
// |           registered result until the consumer takes it.                 |
// | Ports   : clk, rst            clock, async active-high reset             |
// |           prod_data/valid/    product input handshake, prod_last ends    |
// |           last/ready          the group                                  |
// |           clear               abort the current group (ACCUM only)       |
// |           acc_data/count/     result: saturated sum, saturated product   |
// |           overflow            count, sticky saturation flag              |
// |           acc_valid/ready     result handshake                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_overflow,
  output logic              acc_valid,
  input  logic              acc_ready
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_sum;
  logic               acc_sat;
  logic [CNT_W-1:0]   cnt_sum;
  logic               cnt_sat;
  logic               accept;

  product_accumulator_sat_add #(
    .W    (ACC_W),
    .OP_W (PROD_W)
  ) u_acc_add (
    .a   (acc_q),
    .b   (prod_data),
    .sum (acc_sum),
    .ovf (acc_sat)
  );

  product_accumulator_sat_add #(
    .W    (CNT_W),
    .OP_W (1)
  ) u_cnt_add (
    .a   (cnt_q),
    .b   (1'b1),
    .sum (cnt_sum),
    .ovf (cnt_sat)
  );

  // prod_ready is a function of state and clear only, so a clear cycle
  // cannot also accept a product.
  assign prod_ready = (state_q == ST_ACCUM) && !clear;
  assign accept     = prod_valid && prod_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          acc_d = acc_sum;
          // Once the counter has hit its ceiling it simply holds there.
          cnt_d = cnt_sat ? cnt_q : cnt_sum;
          ovf_d = ovf_q | acc_sat;
          if (prod_last) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // clear has no effect here: a presented result is never withdrawn.
        if (acc_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // acc_valid comes straight from the state register, never from acc_ready.
  assign acc_valid    = (state_q == ST_HOLD);
  assign acc_data     = acc_q;
  assign acc_count    = cnt_q;
  assign acc_overflow = ovf_q;

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_product_accumulator                                         |
// | Purpose : Self-checking bench for product_accumulator. Three instances   |
// |           (default, ACC_W=10, CNT_W=2) share data/control inputs, each   |
// |           has its own prod_valid. A group-level reference model keeps    |
// |           the true sum and count and clamps them when compared.          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] prod_data;
  logic       prod_last, clear, acc_ready;
  logic       pv0, pv1, pv2;

  logic        prdy0, avld0, ovf0;
  logic [15:0] ad0;
  logic [7:0]  ac0;
  logic        prdy1, avld1, ovf1;
  logic [9:0]  ad1;
  logic [7:0]  ac1;
  logic        prdy2, avld2, ovf2;
  logic [15:0] ad2;
  logic [1:0]  ac2;

  product_accumulator dut0 (
    .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv0),
    .prod_last(prod_last), .prod_ready(prdy0), .clear(clear),
    .acc_data(ad0), .acc_count(ac0), .acc_overflow(ovf0),
    .acc_valid(avld0), .acc_ready(acc_ready)
  );

  product_accumulator #(.ACC_W(10)) dut1 (
    .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv1),
    .prod_last(prod_last), .prod_ready(prdy1), .clear(clear),
    .acc_data(ad1), .acc_count(ac1), .acc_overflow(ovf1),
    .acc_valid(avld1), .acc_ready(acc_ready)
  );

  product_accumulator #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv2),
    .prod_last(prod_last), .prod_ready(prdy2), .clear(clear),
    .acc_data(ad2), .acc_count(ac2), .acc_overflow(ovf2),
    .acc_valid(avld2), .acc_ready(acc_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model per instance: true (unclamped) group sum and count.
  int amax [3] = '{65535, 1023, 65535};
  int cmax [3] = '{255, 255, 3};
  int m_sum [3];
  int m_cnt [3];
  bit m_hold [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int k, output logic r, output logic v, output logic o,
                        output logic [31:0] d, output logic [31:0] c);
    case (k)
      0:       begin r = prdy0; v = avld0; o = ovf0; d = 32'(ad0); c = 32'(ac0); end
      1:       begin r = prdy1; v = avld1; o = ovf1; d = 32'(ad1); c = 32'(ac1); end
      default: begin r = prdy2; v = avld2; o = ovf2; d = 32'(ad2); c = 32'(ac2); end
    endcase
  endtask

  task automatic model_zero(input int k);
    m_sum[k] = 0;
    m_cnt[k] = 0;
  endtask

  // One clock cycle on instance k: drive, check against the model, clock, update.
  task automatic step(input int k, input bit v, input int d, input bit last,
                      input bit clr, input bit rdy);
    logic r, vl, o;
    logic [31:0] od, oc;
    prod_data = d[7:0];
    prod_last = last;
    clear     = clr;
    acc_ready = rdy;
    pv0 = (k == 0) && v;
    pv1 = (k == 1) && v;
    pv2 = (k == 2) && v;
    #1;
    sample(k, r, vl, o, od, oc);
    chk("prod_ready", 32'(r), 32'(!m_hold[k] && !clr));
    chk("acc_valid", 32'(vl), 32'(m_hold[k]));
    if (m_hold[k]) begin
      chk("acc_data", od, 32'((m_sum[k] > amax[k]) ? amax[k] : m_sum[k]));
      chk("acc_count", oc, 32'((m_cnt[k] > cmax[k]) ? cmax[k] : m_cnt[k]));
      chk("acc_overflow", 32'(o), 32'(m_sum[k] > amax[k]));
    end
    @(posedge clk);
    if (!m_hold[k]) begin
      if (clr) model_zero(k);
      else if (v) begin
        m_sum[k] += d;
        m_cnt[k] += 1;
        if (last) m_hold[k] = 1'b1;
      end
    end else if (rdy) begin
      model_zero(k);
      m_hold[k] = 1'b0;
    end
    #1;
    pv0 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
  endtask

  // Literal result check taken from the directed scenarios.
  task automatic expect_result(input int k, input int d, input int c, input bit o);
    logic r, vl, ov;
    logic [31:0] od, oc;
    #1;
    sample(k, r, vl, ov, od, oc);
    chk("res_valid", 32'(vl), 32'd1);
    chk("res_data", od, 32'(d));
    chk("res_count", oc, 32'(c));
    chk("res_overflow", 32'(ov), 32'(o));
  endtask

  initial begin
    logic r, vl, o;
    logic [31:0] od, oc;
    for (int i = 0; i < 3; i++) begin
      model_zero(i);
      m_hold[i] = 1'b0;
    end
    rst = 1'b1; prod_data = '0; prod_last = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample(0, r, vl, o, od, oc);
    chk("rst_valid", 32'(vl), 32'd0);
    chk("rst_data", od, 32'd0);
    chk("rst_count", oc, 32'd0);
    chk("rst_overflow", 32'(o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(prdy0), 32'd1);

    // Three products of 225.
    step(0, 1, 225, 0, 0, 0);
    step(0, 1, 225, 0, 0, 0);
    step(0, 1, 225, 1, 0, 0);
    expect_result(0, 675, 3, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // ACC_W=10: five products of 225 saturate at 1023.
    for (int i = 0; i < 5; i++) step(1, 1, 225, i == 4, 0, 0);
    expect_result(1, 1023, 5, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);

    // Single product held for four cycles; products offered in HOLD are ignored.
    step(0, 1, 42, 1, 0, 0);
    expect_result(0, 42, 1, 0);
    for (int i = 0; i < 4; i++) step(0, i[0], 77, 1, i[1], 0);
    expect_result(0, 42, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // clear with a concurrent product: 99 is not taken.
    step(0, 1, 10, 0, 0, 0);
    step(0, 1, 20, 0, 0, 0);
    step(0, 1, 99, 0, 1, 0);
    step(0, 1, 7, 1, 0, 0);
    expect_result(0, 7, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // Asynchronous reset between clock edges.
    step(0, 1, 100, 0, 0, 0);
    step(0, 1, 50, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    sample(0, r, vl, o, od, oc);
    chk("async_data", od, 32'd0);
    chk("async_count", oc, 32'd0);
    chk("async_valid", 32'(vl), 32'd0);
    for (int i = 0; i < 3; i++) begin
      model_zero(i);
      m_hold[i] = 1'b0;
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 5, 1, 0, 0);
    expect_result(0, 5, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // CNT_W=2: count saturates at 3.
    for (int i = 0; i < 5; i++) step(2, 1, 1, i == 4, 0, 0);
    expect_result(2, 5, 3, 0);
    step(2, 0, 0, 0, 0, 1);
    step(2, 0, 0, 0, 0, 0);

    // Randomized traffic, first on the default instance, then on ACC_W=10.
    for (int i = 0; i < 250; i++)
      step(0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1));
    // Leave instance 0 empty so the shared controls cannot disturb it.
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 250; i++)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(128, 255), $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_product_accumulator
`default_nettype wire
